lowent_prefix_coder: RTL and testbench

- Sequential front end for the CCSDS-123.0-B-2 hybrid low-entropy coder.
- Accepts one input symbol at a time and grows the active prefix.
- Presents the prefix to an external combinational codebook over a lookup port, the same interface the per-code-index codebook_b*_f tables already use.
- Emits the matched variable-length codeword over a valid/ready stream. Handles flush requests, prefix overflow and output backpressure. Sits between the per-index symbol mapper and the bit packer.

---
 rtl/lowent_prefix_coder.sv | 168 ++++++++++++++++
 tb/tb_lowent_prefix_coder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/lowent_prefix_coder.sv
// Sequential prefix front end for the hybrid low-entropy coder: grows a symbol prefix,
// queries an external codebook, and streams out the matched codeword. Optional LOWENT_STATS_EN.
module lowent_prefix_coder #(
  parameter int SYM_WIDTH           = 4,
  parameter int PREFIX_MAX          = 16,
  parameter int CODEBOOK_LENGTH_MAX = 64,
  parameter int ENCODE_DATALENGTH   = 21,
  parameter int CNT_WIDTH           = 6
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           sym_valid_i,
  output logic                           sym_ready_o,
  input  logic [SYM_WIDTH-1:0]           sym_i,
  input  logic                           flush_i,
  output logic [CNT_WIDTH-1:0]           ap_cnt_o,
  output logic [CODEBOOK_LENGTH_MAX-1:0] ap_data_o,
  output logic                           ap_flush_o,
  input  logic                           lk_match_i,
  input  logic [CNT_WIDTH-1:0]           lk_length_i,
  input  logic [ENCODE_DATALENGTH-1:0]   lk_data_i,
  output logic                           cw_valid_o,
  input  logic                           cw_ready_i,
  output logic [CNT_WIDTH-1:0]           cw_length_o,
  output logic [ENCODE_DATALENGTH-1:0]   cw_data_o,
  output logic                           flush_done_o,
  output logic                           ovf_err_o
`ifdef LOWENT_STATS_EN
  ,
  input  logic                           stat_clr_i,
  output logic [31:0]                    stat_cw_cnt_o,
  output logic [31:0]                    stat_bit_cnt_o
`endif
);

  typedef enum logic [1:0] {ACC, LOOK, EMIT, FLUSH} state_t;

  state_t                         r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0]           r_ap_cnt;
  logic [CODEBOOK_LENGTH_MAX-1:0] r_ap_data;
  logic                           r_cw_valid;
  logic [CNT_WIDTH-1:0]           r_cw_length;
  logic [ENCODE_DATALENGTH-1:0]   r_cw_data;
  logic                           r_flush_pend;
  logic                           r_flush_beat;
  logic                           r_ovf;

  logic w_accept, w_ld_match, w_ld_flush, w_ovf, w_hs, w_flush_done;
  logic [ENCODE_DATALENGTH-1:0] w_mask;

  // Zero codeword bits above the reported length; a shift past the width yields all ones.
  assign w_mask = ~({ENCODE_DATALENGTH{1'b1}} << lk_length_i);

  always_comb begin
    w_state_nxt  = r_state;
    sym_ready_o  = 1'b0;
    ap_flush_o   = 1'b0;
    w_accept     = 1'b0;
    w_ld_match   = 1'b0;
    w_ld_flush   = 1'b0;
    w_ovf        = 1'b0;
    w_hs         = 1'b0;
    w_flush_done = 1'b0;
    case (r_state)
      ACC: begin
        sym_ready_o = ~r_flush_pend;
        if (r_flush_pend) begin
          if (r_ap_cnt == '0) w_flush_done = 1'b1;
          else                w_state_nxt  = FLUSH;
        end else if (sym_valid_i) begin
          w_accept    = 1'b1;
          w_state_nxt = LOOK;
        end
      end
      LOOK: begin
        w_state_nxt = ACC;
        if (lk_match_i) begin
          w_ld_match  = 1'b1;
          w_state_nxt = EMIT;
        end else if (r_ap_cnt == CNT_WIDTH'(PREFIX_MAX)) begin
          w_ovf = 1'b1;
        end
      end
      FLUSH: begin
        ap_flush_o  = 1'b1;
        w_ld_flush  = 1'b1;
        w_state_nxt = EMIT;
      end
      EMIT: begin
        if (cw_ready_i) begin
          w_hs         = 1'b1;
          w_flush_done = r_flush_beat;
          w_state_nxt  = ACC;
        end
      end
      default: w_state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state      <= ACC;
      r_ap_cnt     <= '0;
      r_ap_data    <= '0;
      r_cw_valid   <= 1'b0;
      r_cw_length  <= '0;
      r_cw_data    <= '0;
      r_flush_pend <= 1'b0;
      r_flush_beat <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (w_ld_match || w_ld_flush || w_ovf) begin
        r_ap_cnt  <= '0;
        r_ap_data <= '0;
      end else if (w_accept) begin
        r_ap_cnt  <= r_ap_cnt + CNT_WIDTH'(1);
        r_ap_data <= {r_ap_data[CODEBOOK_LENGTH_MAX-SYM_WIDTH-1:0], sym_i};
      end

      if (w_ld_match || w_ld_flush) begin
        r_cw_valid   <= 1'b1;
        r_cw_length  <= lk_length_i;
        r_cw_data    <= lk_data_i & w_mask;
        r_flush_beat <= w_ld_flush;
      end else if (w_hs) begin
        r_cw_valid   <= 1'b0;
        r_flush_beat <= 1'b0;
      end

      // Pending stays set through the flush beat so a repeat request is absorbed.
      if (w_flush_done)  r_flush_pend <= 1'b0;
      else if (flush_i)  r_flush_pend <= 1'b1;

      if (w_ovf) r_ovf <= 1'b1;
    end
  end

  assign ap_cnt_o     = r_ap_cnt;
  assign ap_data_o    = r_ap_data;
  assign cw_valid_o   = r_cw_valid;
  assign cw_length_o  = r_cw_length;
  assign cw_data_o    = r_cw_data;
  assign flush_done_o = w_flush_done;
  assign ovf_err_o    = r_ovf;

`ifdef LOWENT_STATS_EN
  logic [31:0] r_stat_cw, r_stat_bit;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_stat_cw  <= '0;
      r_stat_bit <= '0;
    end else if (stat_clr_i) begin
      r_stat_cw  <= w_hs ? 32'd1 : 32'd0;
      r_stat_bit <= w_hs ? 32'(r_cw_length) : 32'd0;
    end else if (w_hs) begin
      r_stat_cw  <= r_stat_cw + 32'd1;
      r_stat_bit <= r_stat_bit + 32'(r_cw_length);
    end
  end

  assign stat_cw_cnt_o  = r_stat_cw;
  assign stat_bit_cnt_o = r_stat_bit;
`endif

endmodule

// File: tb/tb_lowent_prefix_coder.sv
// Directed bench for lowent_prefix_coder with a small codebook model attached to the lookup port.
module tb_lowent_prefix_coder;
  localparam int SW = 4, PM = 12, CL = SW*PM, EW = 21, CW = 6;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          sym_valid = 1'b0, sym_ready, flush = 1'b0;
  logic [SW-1:0] sym = '0;
  logic [CW-1:0] ap_cnt, lk_len, cw_len;
  logic [CL-1:0] ap_data;
  logic          ap_flush, lk_match, cw_valid, cw_ready = 1'b1, flush_done, ovf;
  logic [EW-1:0] lk_data, cw_data;
`ifdef LOWENT_STATS_EN
  logic          stat_clr = 1'b0;
  logic [31:0]   stat_cw, stat_bit;
`endif

  int checks = 0, errors = 0, beats = 0;

  always #5 clk = ~clk;

  lowent_prefix_coder #(.SYM_WIDTH(SW), .PREFIX_MAX(PM), .CODEBOOK_LENGTH_MAX(CL),
                        .ENCODE_DATALENGTH(EW), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .sym_valid_i(sym_valid), .sym_ready_o(sym_ready),
    .sym_i(sym), .flush_i(flush), .ap_cnt_o(ap_cnt), .ap_data_o(ap_data),
    .ap_flush_o(ap_flush), .lk_match_i(lk_match), .lk_length_i(lk_len), .lk_data_i(lk_data),
    .cw_valid_o(cw_valid), .cw_ready_i(cw_ready), .cw_length_o(cw_len), .cw_data_o(cw_data),
    .flush_done_o(flush_done), .ovf_err_o(ovf)
`ifdef LOWENT_STATS_EN
    , .stat_clr_i(stat_clr), .stat_cw_cnt_o(stat_cw), .stat_bit_cnt_o(stat_bit)
`endif
  );

  // Codebook model; junk upper data bits exercise the length mask.
  always_comb begin
    lk_match = 1'b0;
    lk_len   = '0;
    lk_data  = 21'h1F0F0F;
    if (ap_flush) begin
      if (ap_cnt == 6'd2) begin lk_len = 6'd8; lk_data = 21'h1FF0A5; end
      else                begin lk_len = 6'd0; lk_data = 21'h1FFFFF; end
    end else if (ap_cnt == 6'd1 && ap_data == 48'hF) begin
      lk_match = 1'b1; lk_len = 6'd12; lk_data = 21'h1FFFFA;
    end else if (ap_cnt == 6'd2 && ap_data == 48'h0F) begin
      lk_match = 1'b1; lk_len = 6'd12; lk_data = 21'h000FFB;
    end else if (ap_cnt == 6'd1 && ap_data == 48'hE) begin
      lk_match = 1'b1; lk_len = 6'd13; lk_data = 21'h001ABC;
    end else if (ap_cnt == 6'd1 && ap_data == 48'hD) begin
      lk_match = 1'b1; lk_len = 6'd18; lk_data = 21'h02ABCD;
    end
  end

  always @(posedge clk) if (rst_n && cw_valid && cw_ready) beats++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Accept one symbol and run its LOOK cycle; ends in ACC or EMIT.
  task automatic push(input logic [SW-1:0] s);
    sym_valid = 1'b1; sym = s;
    step();
    sym_valid = 1'b0;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int b0;
    logic [EW-1:0] held;

    repeat (2) step();
    rst_n = 1'b1;
    chk("rst_cnt", 64'(ap_cnt), 64'd0);
    chk("rst_valid", 64'(cw_valid), 64'd0);
    chk("rst_len", 64'(cw_len), 64'd0);
    chk("rst_data", 64'(cw_data), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_fdone", 64'(flush_done), 64'd0);
    chk("rst_ready", 64'(sym_ready), 64'd1);

    // Single F symbol
    sym_valid = 1'b1; sym = 4'hF;
    step();
    sym_valid = 1'b0;
    chk("f_look_cnt", 64'(ap_cnt), 64'd1);
    chk("f_look_data", 64'(ap_data), 64'hF);
    chk("f_look_rdy", 64'(sym_ready), 64'd0);
    chk("f_look_valid", 64'(cw_valid), 64'd0);
    step();
    chk("f_valid", 64'(cw_valid), 64'd1);
    chk("f_len", 64'(cw_len), 64'd12);
    chk("f_data", 64'(cw_data), 64'hFFA);
    chk("f_cleared", 64'(ap_cnt), 64'd0);
    step();
    chk("f_drop", 64'(cw_valid), 64'd0);

    // 0 then F
    push(4'h0);
    chk("0f_kept_cnt", 64'(ap_cnt), 64'd1);
    chk("0f_novalid", 64'(cw_valid), 64'd0);
    sym_valid = 1'b1; sym = 4'hF;
    step();
    sym_valid = 1'b0;
    chk("0f_look_cnt", 64'(ap_cnt), 64'd2);
    chk("0f_look_data", 64'(ap_data), 64'h0F);
    step();
    chk("0f_len", 64'(cw_len), 64'd12);
    chk("0f_data", 64'(cw_data), 64'hFFB);
    step();

    // Backpressure for 5 cycles
    cw_ready = 1'b0;
    b0 = beats;
    push(4'hF);
    held = cw_data;
    sym_valid = 1'b1; sym = 4'h3;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(cw_valid), 64'd1);
      chk("bp_data", 64'(cw_data), 64'(held));
      chk("bp_len", 64'(cw_len), 64'd12);
      chk("bp_rdy", 64'(sym_ready), 64'd0);
      step();
    end
    sym_valid = 1'b0;
    chk("bp_held_val", 64'(held), 64'hFFA);
    cw_ready = 1'b1;
    step();
    chk("bp_one_beat", 64'(beats - b0), 64'd1);
    chk("bp_drop", 64'(cw_valid), 64'd0);

    // 0,0 then flush
    push(4'h0);
    push(4'h0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_rdy_pend", 64'(sym_ready), 64'd0);
    step();
    chk("fl_apflush", 64'(ap_flush), 64'd1);
    chk("fl_cnt", 64'(ap_cnt), 64'd2);
    chk("fl_data", 64'(ap_data), 64'h0);
    b0 = beats;
    step();
    chk("fl_valid", 64'(cw_valid), 64'd1);
    chk("fl_len", 64'(cw_len), 64'd8);
    chk("fl_cwdata", 64'(cw_data), 64'hA5);
    chk("fl_done_hs", 64'(flush_done), 64'd1);
    step();
    chk("fl_beat", 64'(beats - b0), 64'd1);
    chk("fl_done_end", 64'(flush_done), 64'd0);
    b0 = beats;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl2_done", 64'(flush_done), 64'd1);
    chk("fl2_novalid", 64'(cw_valid), 64'd0);
    step();
    chk("fl2_done_end", 64'(flush_done), 64'd0);
    chk("fl2_nobeat", 64'(beats - b0), 64'd0);

    // Zero-length flush codeword
    push(4'h0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    chk("fz_apflush", 64'(ap_flush), 64'd1);
    step();
    chk("fz_valid", 64'(cw_valid), 64'd1);
    chk("fz_len", 64'(cw_len), 64'd0);
    chk("fz_data", 64'(cw_data), 64'd0);
    step();

    // Overflow at PREFIX_MAX
    b0 = beats;
    for (int i = 0; i < PM - 1; i++) push(4'h0);
    chk("ov_pre_cnt", 64'(ap_cnt), 64'(PM - 1));
    chk("ov_pre_err", 64'(ovf), 64'd0);
    push(4'h0);
    chk("ov_err", 64'(ovf), 64'd1);
    chk("ov_cnt", 64'(ap_cnt), 64'd0);
    chk("ov_novalid", 64'(cw_valid), 64'd0);
    chk("ov_nobeat", 64'(beats - b0), 64'd0);
    push(4'hF);
    chk("ov_f_len", 64'(cw_len), 64'd12);
    chk("ov_f_data", 64'(cw_data), 64'hFFA);
    chk("ov_sticky", 64'(ovf), 64'd1);
    step();

    // Reset during EMIT
    cw_ready = 1'b0;
    push(4'hF);
    chk("re_valid", 64'(cw_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("re_valid0", 64'(cw_valid), 64'd0);
    chk("re_cnt0", 64'(ap_cnt), 64'd0);
    chk("re_ovf0", 64'(ovf), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cw_ready = 1'b1;
    step();

`ifdef LOWENT_STATS_EN
    chk("st_rst_cw", 64'(stat_cw), 64'd0);
    push(4'hF); step();
    push(4'hE); step();
    push(4'hD); step();
    chk("st_cw", 64'(stat_cw), 64'd3);
    chk("st_bits", 64'(stat_bit), 64'd43);
    push(4'hD);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    chk("st_clr_cw", 64'(stat_cw), 64'd1);
    chk("st_clr_bits", 64'(stat_bit), 64'd18);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    chk("st_clr0", 64'(stat_bit), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
